div_seq: RTL and testbench



---
 rtl/div_pkg.sv | 21 ++
 rtl/div_step.sv | 23 ++
 rtl/div_seq.sv | 123 ++++++++++++
 tb/tb_div_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default widths and the iteration-counter width helper.
package div_pkg;

  localparam int DVD_W_DEF = 8;
  localparam int DVS_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Floor of one bit so a degenerate 1-bit dividend still gets a legal counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(DVD_W_DEF);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference when it does not go negative.
module div_step
  import div_pkg::*;
#(
  parameter int DVS_W = DVS_W_DEF
) (
  input  logic [DVS_W-1:0] i_r,
  input  logic             i_q_msb,
  input  logic [DVS_W-1:0] i_d,
  output logic [DVS_W:0]   o_r,
  output logic             o_q_bit
);

  logic [DVS_W:0]   w_rs;
  logic [DVS_W+1:0] w_diff;

  assign w_rs    = {i_r, i_q_msb};
  assign w_diff  = {1'b0, w_rs} - {2'b00, i_d};
  assign o_q_bit = ~w_diff[DVS_W+1];
  assign o_r     = o_q_bit ? w_diff[DVS_W:0] : w_rs;

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider, one shift-subtract step per clock with a
// start/done handshake. Define DIV_ZERO_TRAP_EN to trap zero divisors in one cycle.
module div_seq
  import div_pkg::*;
#(
  parameter int DVD_W = DVD_W_DEF,
  parameter int DVS_W = DVS_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int             CNT_W = cnt_width(DVD_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DVD_W - 1);

  state_t           r_state;
  logic [DVD_W-1:0] r_q;
  logic [DVS_W:0]   r_r;
  logic [DVS_W-1:0] r_d;
  logic [CNT_W-1:0] r_cnt;
  logic [DVD_W-1:0] r_quotient;
  logic [DVS_W-1:0] r_remainder;
  logic             r_busy;
  logic             r_done;

  logic [DVS_W:0]   w_r_next;
  logic             w_q_bit;
  logic [DVD_W-1:0] w_q_next;
  logic             w_unused_rmsb;

  div_step #(.DVS_W(DVS_W)) u_step (
    .i_r     (r_r[DVS_W-1:0]),
    .i_q_msb (r_q[DVD_W-1]),
    .i_d     (r_d),
    .o_r     (w_r_next),
    .o_q_bit (w_q_bit)
  );

  assign w_q_next = {r_q[DVD_W-2:0], w_q_bit};
  // Only the low DVS_W bits of R ever feed the next step or the result.
  assign w_unused_rmsb = r_r[DVS_W];

`ifdef DIV_ZERO_TRAP_EN
  logic r_err;
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_q         <= '0;
      r_r         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      r_err       <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_q   <= dividend;
            r_d   <= divisor;
            r_r   <= '0;
            r_cnt <= '0;
`ifdef DIV_ZERO_TRAP_EN
            if (divisor == '0) begin
              r_state     <= DONE;
              r_quotient  <= '1;
              r_remainder <= dividend[DVS_W-1:0];
              r_done      <= 1'b1;
              r_err       <= 1'b1;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
              r_err   <= 1'b0;
            end
`else
            r_state <= RUN;
            r_busy  <= 1'b1;
`endif
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_q   <= w_q_next;
          r_r   <= w_r_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state     <= DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_quotient  <= w_q_next;
            r_remainder <= w_r_next[DVS_W-1:0];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases plus randomized operands
// compared against plain integer division.
module tb_div_seq;

  localparam int DVD_W = 8;
  localparam int DVS_W = 4;
`ifdef DIV_ZERO_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [DVD_W-1:0] dividend = '0;
  logic [DVS_W-1:0] divisor = '0;
  logic [DVD_W-1:0] quotient;
  logic [DVS_W-1:0] remainder;
  logic             busy;
  logic             done;
  logic             err;

  int checks = 0;
  int errors = 0;

  div_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reference: ordinary unsigned division; zero divisor gives all ones and
  // the low dividend bits, trapped in one edge when the trap is built in.
  task automatic ref_div(input logic [DVD_W-1:0] a, input logic [DVS_W-1:0] b,
                         output logic [DVD_W-1:0] q, output logic [DVS_W-1:0] r,
                         output logic e, output int lat);
    if (b == 0) begin
      q   = '1;
      r   = DVS_W'(a % (1 << DVS_W));
      e   = TRAP;
      lat = TRAP ? 1 : DVD_W + 1;
    end else begin
      q   = DVD_W'(int'(a) / int'(b));
      r   = DVS_W'(int'(a) % int'(b));
      e   = 1'b0;
      lat = DVD_W + 1;
    end
  endtask

  // Drives one operation (called #1 after an edge) and measures the number of
  // edges from the accepting edge up to the one after which done is seen.
  task automatic do_op(input logic [DVD_W-1:0] a, input logic [DVS_W-1:0] b,
                       output int lat, output int busy_cyc);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    lat      = 1;
    busy_cyc = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cyc++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({quotient, remainder, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got q=%0d r=%0d busy=%b done=%b err=%b, expected all 0",
               quotient, remainder, busy, done, err);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({quotient, remainder, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: got q=%0d r=%0d busy=%b done=%b err=%b, expected all 0",
               quotient, remainder, busy, done, err);
    end
  endtask

  task automatic test_directed();
    logic [DVD_W-1:0] dvd [5] = '{8'd200, 8'd255, 8'd5, 8'd255, 8'd9};
    logic [DVS_W-1:0] dvs [5] = '{4'd7, 4'd15, 4'd9, 4'd1, 4'd2};
    logic [DVD_W-1:0] eq [5]  = '{8'd28, 8'd17, 8'd0, 8'd255, 8'd4};
    logic [DVS_W-1:0] er [5]  = '{4'd4, 4'd0, 4'd5, 4'd0, 4'd1};
    int lat, bc;
    for (int i = 0; i < 5; i++) begin
      do_op(dvd[i], dvs[i], lat, bc);
      checks++;
      if (lat !== 9 || bc !== 8) begin
        errors++;
        $display("FAIL directed_timing %0d/%0d: got latency=%0d busy=%0d, expected 9 and 8",
                 dvd[i], dvs[i], lat, bc);
      end
      checks++;
      if (quotient !== eq[i] || remainder !== er[i] || err !== 1'b0) begin
        errors++;
        $display("FAIL directed_result %0d/%0d: got q=%0d r=%0d err=%b, expected q=%0d r=%0d err=0",
                 dvd[i], dvs[i], quotient, remainder, err, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_zero_div();
    int lat, bc;
    do_op(8'hA6, 4'd0, lat, bc);
    checks++;
    if (lat !== (TRAP ? 1 : 9) || quotient !== 8'hFF || remainder !== 4'h6 || err !== TRAP) begin
      errors++;
      $display("FAIL zero_divisor: got lat=%0d q=%h r=%h err=%b, expected lat=%0d q=ff r=6 err=%b",
               lat, quotient, remainder, err, TRAP ? 1 : 9, TRAP);
    end
    do_op(8'd200, 4'd7, lat, bc);
    checks++;
    if (err !== 1'b0 || quotient !== 8'd28 || remainder !== 4'd4) begin
      errors++;
      $display("FAIL err_cleared: got q=%0d r=%0d err=%b, expected q=28 r=4 err=0",
               quotient, remainder, err);
    end
  endtask

  task automatic test_ignore_start();
    int edges;
    dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; edges = 1;
    repeat (2) begin @(posedge clk); #1; edges++; end
    dividend = 8'd13; divisor = 4'd2; start = 1'b1;
    @(posedge clk); #1; edges++;
    start = 1'b0; dividend = 8'd77;
    @(posedge clk); #1; edges++;
    dividend = 8'd99; divisor = 4'd3; start = 1'b1;
    @(posedge clk); #1; edges++;
    start = 1'b0;
    while (!done && edges < 40) begin @(posedge clk); #1; edges++; end
    checks++;
    if (edges !== 9 || quotient !== 8'd28 || remainder !== 4'd4) begin
      errors++;
      $display("FAIL ignore_start: got edges=%0d q=%0d r=%0d, expected 9 q=28 r=4",
               edges, quotient, remainder);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    do_op(8'd100, 4'd3, lat, bc);
    checks++;
    if (lat !== 9 || quotient !== 8'd33 || remainder !== 4'd1) begin
      errors++;
      $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d, expected 9 q=33 r=1",
               lat, quotient, remainder);
    end
    // Issued while done is high, i.e. in the DONE cycle.
    do_op(8'd77, 4'd6, lat, bc);
    checks++;
    if (lat !== 9 || quotient !== 8'd12 || remainder !== 4'd5) begin
      errors++;
      $display("FAIL b2b_second: got done_gap=%0d q=%0d r=%0d, expected 9 q=12 r=5",
               lat, quotient, remainder);
    end
  endtask

  task automatic test_async_reset();
    int lat, bc, seen_done;
    dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    checks++;
    if ({quotient, remainder, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL async_reset: got q=%0d r=%0d busy=%b done=%b err=%b, expected all 0",
               quotient, remainder, busy, done, err);
    end
    seen_done = 0;
    @(negedge clk); rst_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; if (done || busy) seen_done++; end
    checks++;
    if (seen_done !== 0) begin
      errors++;
      $display("FAIL no_done_after_abort: got %0d cycles with done/busy, expected 0", seen_done);
    end
    do_op(8'd9, 4'd2, lat, bc);
    checks++;
    if (lat !== 9 || quotient !== 8'd4 || remainder !== 4'd1) begin
      errors++;
      $display("FAIL after_reset_op: got lat=%0d q=%0d r=%0d, expected 9 q=4 r=1",
               lat, quotient, remainder);
    end
  endtask

  task automatic test_random();
    logic [DVD_W-1:0] a, eq;
    logic [DVS_W-1:0] b, er;
    logic ee;
    int lat, elat, bc;
    for (int i = 0; i < 40; i++) begin
      a = DVD_W'($urandom_range(0, 255));
      b = (i % 8 == 0) ? 4'd0 : DVS_W'($urandom_range(0, 15));
      ref_div(a, b, eq, er, ee, elat);
      do_op(a, b, lat, bc);
      checks++;
      if (lat !== elat || quotient !== eq || remainder !== er || err !== ee) begin
        errors++;
        $display("FAIL random %0d/%0d: got lat=%0d q=%0d r=%0d err=%b, expected lat=%0d q=%0d r=%0d err=%b",
                 a, b, lat, quotient, remainder, err, elat, eq, er, ee);
      end
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_div();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
